id_ex_hazard_reg: RTL and testbench
===================================

ID_EX_HAZARD_REG -- requirements
Module: id_ex_hazard_reg

Interface
REQ-001 SHALL have ports: Clk in 1 clock; Reset_n in 1 asynchronous active-low reset; one clock, no other clock or reset.
REQ-002 SHALL have ID inputs: ID_Valid 1; ID_Rs, ID_Rt, ID_Rd 5 each; ID_UsesRt 1 (Rt is a read source); ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC4 32 each.
REQ-003 SHALL have ID control inputs: ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst, ID_isBranch 1 each; ID_ALUOp 4.
REQ-004 SHALL have pipeline control inputs: Hold 1 (global freeze); Flush 1 (squash instruction entering EX).
REQ-005 SHALL have EX outputs: EX_Rs, EX_Rt, EX_WriteReg 5; EX_ReadData1, EX_ReadData2, EX_Imm, EX_PC4 32; EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_isStore, EX_Valid 1; EX_ALUOp 4.
REQ-006 SHALL have hazard outputs: Stall 1 (freeze PC and IF/ID); StallCount 16 (saturating stall-cycle counter).

Function
REQ-007 SHALL register all EX_* outputs on Clk rising edge; one-cycle ID-to-EX latency.
REQ-008 SHALL compute EX_WriteReg at capture: ID_RegDst ? ID_Rd : ID_Rt; EX_isStore SHALL equal registered ID_MemWrite.
REQ-009 SHALL assert Stall combinationally for load-use: ID_Valid && EX_MemRead && EX_WriteReg!=0 && (EX_WriteReg==ID_Rs || (ID_UsesRt && EX_WriteReg==ID_Rt)).
REQ-010 SHALL assert Stall combinationally for branch-on-ALU-result: ID_Valid && ID_isBranch && EX_RegWrite && !EX_MemRead && EX_WriteReg!=0 && EX_WriteReg matches ID_Rs or ID_Rt.
REQ-011 SHALL resolve branch-on-load with one stall only (REQ-009); MEM-stage data-memory branch forwarding covers the following cycle.
REQ-012 SHALL apply per-edge priority: Hold > Flush > Stall > normal load.
REQ-013 Hold: all EX_* registers and StallCount SHALL retain values; Stall output still reflects REQ-009/010.
REQ-014 Flush or Stall (no Hold): SHALL load bubble -- all EX control bits, EX_Valid, EX_Rs, EX_Rt, EX_WriteReg zero; data fields don't-care but SHALL be zeroed.
REQ-015 ID_Valid=0 with normal load SHALL capture a bubble identical to REQ-014.
REQ-016 Bubble SHALL never cause a stall or forwarding match (register ids zero).
REQ-017 StallCount SHALL increment by 1 each edge where Stall=1 and Hold=0, saturating at 16'hFFFF; Flush coincident with Stall still counts.
REQ-018 Back-to-back dependents SHALL stall exactly once each; after a bubble the dependent instruction SHALL load normally.

Reset
REQ-019 Reset_n low SHALL asynchronously clear all EX_* outputs and StallCount to zero; Stall then 0 (depends on cleared EX state and ID_Valid).
REQ-020 Reset mid-stall SHALL discard the stalled state; first edge after release loads normally.

Structure
REQ-021 Bubble constant, ALUOp encodings and register-index width SHALL live in shared package pipeline_pkg.
REQ-022 Hazard comparison SHALL be a sub-module hazard_detect (combinational, instanced once); registers stay in top.

Verification
REQ-023 lw $t0 in EX (EX_MemRead=1, EX_WriteReg=8), ID add with ID_Rs=8 -> Stall=1, next edge EX_Valid=0, EX_RegWrite=0, StallCount=1.
REQ-024 EX add writes $9, ID beq ID_Rt=9, ID_isBranch=1 -> Stall=1 one cycle; same with EX_WriteReg=0 -> Stall=0.
REQ-025 Stall=1 and Hold=1 same edge -> EX outputs unchanged, StallCount unchanged; Hold released -> bubble, count+1.
REQ-026 Flush=1 with valid ID sw (ID_MemWrite=1) -> next EX_isStore=0, EX_Valid=0; without Flush -> EX_isStore=1, EX_WriteReg=ID_Rt.
REQ-027 StallCount preset to 16'hFFFE, three stall edges -> reads 16'hFFFF; Reset_n pulsed low between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-index width, ALU op encodings and the
// ID/EX pipeline-register layout with its bubble constant.
package pipeline_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef struct packed {
    reg_idx_t    rs;
    reg_idx_t    rt;
    reg_idx_t    write_reg;
    word_t       read_data1;
    word_t       read_data2;
    word_t       imm;
    word_t       pc4;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        valid;
    logic [3:0]  alu_op;
  } ex_ctrl_t;

  // A bubble has zero register ids, so it can never match a hazard compare.
  localparam ex_ctrl_t EX_BUBBLE = '0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// ID/EX boundary bundle: decoded ID instruction in, EX-stage view and hazard
// status out. The ID side (decoder/testbench) is the master.
interface id_ex_hazard_reg_if;
  import pipeline_pkg::*;

  logic       ID_Valid;
  reg_idx_t   ID_Rs, ID_Rt, ID_Rd;
  logic       ID_UsesRt;
  word_t      ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC4;
  logic       ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg;
  logic       ID_ALUSrc, ID_RegDst, ID_isBranch;
  logic [3:0] ID_ALUOp;
  logic       Hold, Flush;

  reg_idx_t   EX_Rs, EX_Rt, EX_WriteReg;
  word_t      EX_ReadData1, EX_ReadData2, EX_Imm, EX_PC4;
  logic       EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg;
  logic       EX_ALUSrc, EX_isStore, EX_Valid;
  logic [3:0] EX_ALUOp;
  logic       Stall;
  logic [15:0] StallCount;

  modport master (
    output ID_Valid, ID_Rs, ID_Rt, ID_Rd, ID_UsesRt,
    output ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC4,
    output ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg,
    output ID_ALUSrc, ID_RegDst, ID_isBranch, ID_ALUOp, Hold, Flush,
    input  EX_Rs, EX_Rt, EX_WriteReg, EX_ReadData1, EX_ReadData2, EX_Imm, EX_PC4,
    input  EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc,
    input  EX_isStore, EX_Valid, EX_ALUOp, Stall, StallCount
  );

  modport slave (
    input  ID_Valid, ID_Rs, ID_Rt, ID_Rd, ID_UsesRt,
    input  ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC4,
    input  ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg,
    input  ID_ALUSrc, ID_RegDst, ID_isBranch, ID_ALUOp, Hold, Flush,
    output EX_Rs, EX_Rt, EX_WriteReg, EX_ReadData1, EX_ReadData2, EX_Imm, EX_PC4,
    output EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc,
    output EX_isStore, EX_Valid, EX_ALUOp, Stall, StallCount
  );

endinterface

// File: rtl/id_ex_hazard_reg_hazard_detect.sv
// Combinational hazard compare between the ID instruction and the EX register.
// Branch-on-load is left to the load-use term; MEM forwarding covers the rest.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic     id_valid_i,
  input  reg_idx_t id_rs_i,
  input  reg_idx_t id_rt_i,
  input  logic     id_uses_rt_i,
  input  logic     id_is_branch_i,
  input  logic     ex_mem_read_i,
  input  logic     ex_reg_write_i,
  input  reg_idx_t ex_write_reg_i,
  output logic     stall_o
);

  logic load_use_s;
  logic branch_alu_s;
  logic wr_live_s;

  // Load-use and branch-on-ALU-result terms.
  always_comb begin
    wr_live_s    = (ex_write_reg_i != REG_ZERO);
    load_use_s   = id_valid_i && ex_mem_read_i && wr_live_s &&
                   ((ex_write_reg_i == id_rs_i) ||
                    (id_uses_rt_i && (ex_write_reg_i == id_rt_i)));
    branch_alu_s = id_valid_i && id_is_branch_i && ex_reg_write_i &&
                   !ex_mem_read_i && wr_live_s &&
                   ((ex_write_reg_i == id_rs_i) || (ex_write_reg_i == id_rt_i));
    stall_o      = load_use_s || branch_alu_s;
  end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with hazard stall generation and a saturating
// stall-cycle counter. Edge priority: Hold > Flush > Stall > normal load.
module id_ex_hazard_reg
  import pipeline_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  id_ex_hazard_reg_if.slave  bus
);

  ex_ctrl_t    ex_d, ex_q;
  ex_ctrl_t    capture_s;
  logic [15:0] stall_cnt_d, stall_cnt_q;
  logic        stall_s;

  hazard_detect u_hazard (
    .id_valid_i     (bus.ID_Valid),
    .id_rs_i        (bus.ID_Rs),
    .id_rt_i        (bus.ID_Rt),
    .id_uses_rt_i   (bus.ID_UsesRt),
    .id_is_branch_i (bus.ID_isBranch),
    .ex_mem_read_i  (ex_q.mem_read),
    .ex_reg_write_i (ex_q.reg_write),
    .ex_write_reg_i (ex_q.write_reg),
    .stall_o        (stall_s)
  );

  // Destination register is resolved here so EX sees a single write index.
  always_comb begin
    capture_s            = EX_BUBBLE;
    capture_s.rs         = bus.ID_Rs;
    capture_s.rt         = bus.ID_Rt;
    capture_s.write_reg  = bus.ID_RegDst ? bus.ID_Rd : bus.ID_Rt;
    capture_s.read_data1 = bus.ID_ReadData1;
    capture_s.read_data2 = bus.ID_ReadData2;
    capture_s.imm        = bus.ID_Imm;
    capture_s.pc4        = bus.ID_PC4;
    capture_s.reg_write  = bus.ID_RegWrite;
    capture_s.mem_read   = bus.ID_MemRead;
    capture_s.mem_write  = bus.ID_MemWrite;
    capture_s.mem_to_reg = bus.ID_MemToReg;
    capture_s.alu_src    = bus.ID_ALUSrc;
    capture_s.valid      = 1'b1;
    capture_s.alu_op     = bus.ID_ALUOp;
  end

  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.Hold) begin
      ex_d        = ex_q;
      stall_cnt_d = stall_cnt_q;
    end else begin
      if (bus.Flush || stall_s || !bus.ID_Valid) begin
        ex_d = EX_BUBBLE;
      end else begin
        ex_d = capture_s;
      end
      // A flushed stall edge still counts as a stall cycle.
      if (stall_s) begin
        stall_cnt_d = sat_inc16(stall_cnt_q);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ex_q        <= EX_BUBBLE;
      stall_cnt_q <= 16'h0000;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.EX_Rs        = ex_q.rs;
  assign bus.EX_Rt        = ex_q.rt;
  assign bus.EX_WriteReg  = ex_q.write_reg;
  assign bus.EX_ReadData1 = ex_q.read_data1;
  assign bus.EX_ReadData2 = ex_q.read_data2;
  assign bus.EX_Imm       = ex_q.imm;
  assign bus.EX_PC4       = ex_q.pc4;
  assign bus.EX_RegWrite  = ex_q.reg_write;
  assign bus.EX_MemRead   = ex_q.mem_read;
  assign bus.EX_MemWrite  = ex_q.mem_write;
  assign bus.EX_MemToReg  = ex_q.mem_to_reg;
  assign bus.EX_ALUSrc    = ex_q.alu_src;
  assign bus.EX_isStore   = ex_q.mem_write;
  assign bus.EX_Valid     = ex_q.valid;
  assign bus.EX_ALUOp     = ex_q.alu_op;
  assign bus.Stall        = stall_s;
  assign bus.StallCount   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Table-driven bench for id_ex_hazard_reg: each vector's expected EX state is
// queued when driven and compared after the capturing edge.
module tb_id_ex_hazard_reg;
  import pipeline_pkg::*;

  logic clk;
  logic rst_n;

  id_ex_hazard_reg_if bus();

  id_ex_hazard_reg dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, rd;
    logic       urt, br, rw, mr, mw, rdst, hold, flush;
    logic       e_stall, e_v;
    logic [4:0] e_wr;
    logic       e_st, e_rw;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic         v;
    logic [4:0]   wr;
    logic         st, rw;
    logic [15:0]  cnt;
    logic [144:0] bundle;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[19];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input int v, rs, rt, rd, urt, br, rw, mr, mw, rdst,
                              flush, es, ev, ewr, est, erw, ecnt);
    vec_t t;
    t.v = 1'(v);  t.rs = 5'(rs);  t.rt = 5'(rt);  t.rd = 5'(rd);
    t.urt = 1'(urt);  t.br = 1'(br);  t.rw = 1'(rw);  t.mr = 1'(mr);
    t.mw = 1'(mw);  t.rdst = 1'(rdst);  t.hold = 1'b0;  t.flush = 1'(flush);
    t.e_stall = 1'(es);  t.e_v = 1'(ev);  t.e_wr = 5'(ewr);
    t.e_st = 1'(est);  t.e_rw = 1'(erw);  t.e_cnt = 16'(ecnt);
    return t;
  endfunction

  // Data/aux fields the EX register should hold: the ID values if live, else zero.
  function automatic logic [144:0] gen_bundle(input vec_t t, input int idx, input logic live);
    if (!live) return 145'd0;
    return {t.rs, t.rt, 32'hA000_0000 + 32'(idx), 32'hB000_0000 + 32'(idx),
            32'h0000_0100 + 32'(idx), 32'h0040_0000 + 32'(4 * idx),
            t.mr, t.mr, t.mr | t.mw, 4'(idx)};
  endfunction

  function automatic logic [144:0] act_bundle();
    return {bus.EX_Rs, bus.EX_Rt, bus.EX_ReadData1, bus.EX_ReadData2, bus.EX_Imm,
            bus.EX_PC4, bus.EX_MemRead, bus.EX_MemToReg, bus.EX_ALUSrc, bus.EX_ALUOp};
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t, input int idx);
    bus.ID_Valid     = t.v;
    bus.ID_Rs        = t.rs;
    bus.ID_Rt        = t.rt;
    bus.ID_Rd        = t.rd;
    bus.ID_UsesRt    = t.urt;
    bus.ID_ReadData1 = 32'hA000_0000 + 32'(idx);
    bus.ID_ReadData2 = 32'hB000_0000 + 32'(idx);
    bus.ID_Imm       = 32'h0000_0100 + 32'(idx);
    bus.ID_PC4       = 32'h0040_0000 + 32'(4 * idx);
    bus.ID_RegWrite  = t.rw;
    bus.ID_MemRead   = t.mr;
    bus.ID_MemWrite  = t.mw;
    bus.ID_MemToReg  = t.mr;
    bus.ID_ALUSrc    = t.mr | t.mw;
    bus.ID_RegDst    = t.rdst;
    bus.ID_isBranch  = t.br;
    bus.ID_ALUOp     = 4'(idx);
    bus.Hold         = t.hold;
    bus.Flush        = t.flush;
  endtask

  // One vector: drive at negedge, check Stall, queue expectation, compare after edge.
  task automatic run(input vec_t t, input int idx);
    exp_t e;
    exp_t got;
    @(negedge clk);
    drive(t, idx);
    #1;
    chk($sformatf("stall[%0d]", idx), 192'(bus.Stall), 192'(t.e_stall));
    e.v = t.e_v;  e.wr = t.e_wr;  e.st = t.e_st;  e.rw = t.e_rw;  e.cnt = t.e_cnt;
    e.bundle = gen_bundle(t, idx, t.e_v);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard[%0d]: got empty queue expected one entry", idx);
    end else begin
      got = sb_q.pop_front();
      chk($sformatf("ex_valid[%0d]", idx),    192'(bus.EX_Valid),    192'(got.v));
      chk($sformatf("ex_wr[%0d]", idx),       192'(bus.EX_WriteReg), 192'(got.wr));
      chk($sformatf("ex_isstore[%0d]", idx),  192'(bus.EX_isStore),  192'(got.st));
      chk($sformatf("ex_regwrite[%0d]", idx), 192'(bus.EX_RegWrite), 192'(got.rw));
      chk($sformatf("stallcount[%0d]", idx),  192'(bus.StallCount),  192'(got.cnt));
      chk($sformatf("ex_fields[%0d]", idx),   192'(act_bundle()),    192'(got.bundle));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        lw8, add_st, add_ld, rst_probe;
    logic [15:0] c;

    tbl[0]  = mk(1,1,2,3,1,0,1,0,0,1,0,  0,1,3,0,1,0);   // add $3
    tbl[1]  = mk(1,4,8,0,0,0,1,1,0,0,0,  0,1,8,0,1,0);   // lw $8
    tbl[2]  = mk(1,8,5,10,1,0,1,0,0,1,0, 1,0,0,0,0,1);   // add uses $8 -> stall
    tbl[3]  = mk(1,8,5,10,1,0,1,0,0,1,0, 0,1,10,0,1,1);  // reissue loads
    tbl[4]  = mk(1,1,2,9,1,0,1,0,0,1,0,  0,1,9,0,1,1);   // add $9
    tbl[5]  = mk(1,0,9,0,1,1,0,0,0,0,0,  1,0,0,0,0,2);   // beq on $9 -> stall
    tbl[6]  = mk(1,0,9,0,1,1,0,0,0,0,0,  0,1,9,0,0,2);
    tbl[7]  = mk(1,2,9,0,1,0,0,0,1,0,0,  0,1,9,1,0,2);   // sw, no flush
    tbl[8]  = mk(1,2,9,0,1,0,0,0,1,0,1,  0,0,0,0,0,2);   // sw flushed
    tbl[9]  = mk(1,2,7,0,0,0,1,1,0,0,0,  0,1,7,0,1,2);   // lw $7
    tbl[10] = mk(1,7,6,0,0,0,1,1,0,0,0,  1,0,0,0,0,3);   // lw $6 uses $7 -> stall
    tbl[11] = mk(1,7,6,0,0,0,1,1,0,0,0,  0,1,6,0,1,3);
    tbl[12] = mk(1,2,6,0,0,0,1,0,0,0,0,  0,1,6,0,1,3);   // rt match, not a source
    tbl[13] = mk(1,6,6,1,1,0,1,0,0,1,0,  0,1,1,0,1,3);   // ALU producer, no stall
    tbl[14] = mk(0,1,0,0,0,1,1,0,0,0,0,  0,0,0,0,0,3);   // invalid ID -> bubble
    tbl[15] = mk(1,0,5,0,0,0,1,1,0,0,0,  0,1,5,0,1,3);   // lw $5
    tbl[16] = mk(1,5,3,4,1,0,1,0,0,1,1,  1,0,0,0,0,4);   // stall + flush counts
    tbl[17] = mk(1,0,0,0,1,0,1,0,0,1,0,  0,1,0,0,1,4);   // writes $0
    tbl[18] = mk(1,0,0,0,1,1,0,0,0,0,0,  0,1,0,0,0,4);   // beq vs $0 -> no stall

    // Reset state, with an ID instruction that would hazard on any non-zero EX.
    rst_n = 1'b0;
    rst_probe = mk(1,8,8,1,1,1,1,0,0,1,0, 0,0,0,0,0,0);
    drive(rst_probe, 0);
    #12;
    chk("rst_ex_valid",   192'(bus.EX_Valid),    192'(1'b0));
    chk("rst_ex_wr",      192'(bus.EX_WriteReg), 192'(5'd0));
    chk("rst_regwrite",   192'(bus.EX_RegWrite), 192'(1'b0));
    chk("rst_stallcount", 192'(bus.StallCount),  192'(16'd0));
    chk("rst_fields",     192'(act_bundle()),    192'(145'd0));
    chk("rst_stall",      192'(bus.Stall),       192'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) run(tbl[i], i);

    // Hold coincident with a load-use stall freezes everything.
    lw8    = mk(1,4,8,0,0,0,1,1,0,0,0,  0,1,8,0,1,4);
    add_st = mk(1,8,5,10,1,0,1,0,0,1,0, 1,0,0,0,0,5);
    add_ld = mk(1,8,5,10,1,0,1,0,0,1,0, 0,1,10,0,1,5);
    run(lw8, 20);
    @(negedge clk);
    add_st.hold = 1'b1;
    drive(add_st, 21);
    #1;
    chk("hold_stall", 192'(bus.Stall), 192'(1'b1));
    @(posedge clk);
    #1;
    chk("hold_ex_valid", 192'(bus.EX_Valid),    192'(1'b1));
    chk("hold_ex_wr",    192'(bus.EX_WriteReg), 192'(5'd8));
    chk("hold_fields",   192'(act_bundle()),    192'(gen_bundle(lw8, 20, 1'b1)));
    chk("hold_count",    192'(bus.StallCount),  192'(16'd4));
    @(negedge clk);
    bus.Hold = 1'b0;
    #1;
    chk("unhold_stall", 192'(bus.Stall), 192'(1'b1));
    @(posedge clk);
    #1;
    chk("unhold_ex_valid", 192'(bus.EX_Valid),    192'(1'b0));
    chk("unhold_regwrite", 192'(bus.EX_RegWrite), 192'(1'b0));
    chk("unhold_count",    192'(bus.StallCount),  192'(16'd5));
    run(add_ld, 22);

    // Saturation: preset near the top, then three stall edges.
    @(negedge clk);
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    #1;
    chk("preset_count", 192'(bus.StallCount), 192'(16'hFFFE));
    c = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      lw8.e_cnt = c;
      run(lw8, 30 + 3 * k);
      c = (c == 16'hFFFF) ? c : c + 16'd1;
      add_st.e_cnt = c;
      add_st.hold  = 1'b0;
      run(add_st, 31 + 3 * k);
      add_ld.e_cnt = c;
      run(add_ld, 32 + 3 * k);
    end
    chk("sat_count", 192'(bus.StallCount), 192'(16'hFFFF));

    // Reset asserted mid-stall clears immediately; first edge after release loads.
    lw8.e_cnt = 16'hFFFF;
    run(lw8, 40);
    @(negedge clk);
    drive(add_st, 41);
    #1;
    chk("midrst_stall_pre", 192'(bus.Stall), 192'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("midrst_ex_valid", 192'(bus.EX_Valid),    192'(1'b0));
    chk("midrst_ex_wr",    192'(bus.EX_WriteReg), 192'(5'd0));
    chk("midrst_memread",  192'(bus.EX_MemRead),  192'(1'b0));
    chk("midrst_count",    192'(bus.StallCount),  192'(16'd0));
    chk("midrst_stall",    192'(bus.Stall),       192'(1'b0));
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_ex_valid", 192'(bus.EX_Valid),    192'(1'b1));
    chk("postrst_ex_wr",    192'(bus.EX_WriteReg), 192'(5'd10));
    chk("postrst_regwrite", 192'(bus.EX_RegWrite), 192'(1'b1));
    chk("postrst_fields",   192'(act_bundle()),    192'(gen_bundle(add_st, 41, 1'b1)));
    chk("postrst_count",    192'(bus.StallCount),  192'(16'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
